// File: rtl/fetch_align_ctrl.sv
`timescale 1ns/1ps
// Instruction fetch aligner for the C extension: buffers one icache word and
// presents 16-bit or 32-bit instructions at halfword-aligned PCs, stitching straddlers.
module fetch_align_ctrl #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            word_valid_i,
  input  logic [31:0]     word_i,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  output logic            req_kill_o,
  output logic [31:0]     instr_o,
  output logic            instr_valid_o,
  output logic            is_comp_o,
  output logic            stall_o
);

  typedef enum logic [1:0] {S_LOOKUP, S_WAIT, S_CROSS, S_HOLD} state_t;

  localparam logic [XLEN-3:0] TAG_ONE = {{(XLEN-3){1'b0}}, 1'b1};

  state_t          state_reg;
  state_t          state_next;

  logic [31:0]     buf_word_q;
  logic [XLEN-3:0] buf_tag_q;
  logic            buf_vld_q;
  logic [15:0]     half_q;
  logic [31:0]     hold_q;
  logic [XLEN-3:0] addr_tag_q;

  logic [XLEN-3:0] pc_tag;
  logic [15:0]     parcel [2];
  logic [15:0]     h;
  logic            hit;
  logic            h_is32;
  logic            straddle;
  logic            kill;
  logic            unused_pc_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_parcel
      assign parcel[gi] = buf_word_q[16*gi +: 16];
    end
  endgenerate

  assign pc_tag        = pc_i[XLEN-1:2];
  assign unused_pc_lsb = pc_i[0];
  assign hit           = buf_vld_q && (buf_tag_q == pc_tag);
  assign h             = pc_i[1] ? parcel[1] : parcel[0];
  assign h_is32        = (h[1:0] == 2'b11);
  assign straddle      = h_is32 && pc_i[1];
  assign kill          = redirect_i || flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_LOOKUP;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = S_LOOKUP;
    end else begin
      case (state_reg)
        S_LOOKUP: begin
          if (!hit) begin
            state_next = S_WAIT;
          end else if (straddle) begin
            state_next = S_CROSS;
          end
        end
        S_WAIT:  if (word_valid_i) state_next = S_LOOKUP;
        S_CROSS: if (word_valid_i) state_next = S_HOLD;
        S_HOLD:  if (!stall_i) state_next = S_LOOKUP;
        default: state_next = S_LOOKUP;
      endcase
    end
  end

  // A redirect leaves the buffer intact and drops any acknowledge arriving with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_word_q <= '0;
      buf_tag_q  <= '0;
      buf_vld_q  <= 1'b0;
      half_q     <= '0;
      hold_q     <= '0;
      addr_tag_q <= '0;
    end else if (flush_i) begin
      buf_vld_q <= 1'b0;
    end else if (!redirect_i) begin
      case (state_reg)
        S_LOOKUP: begin
          if (!hit) begin
            addr_tag_q <= pc_tag;
          end else if (straddle) begin
            half_q     <= h;
            addr_tag_q <= buf_tag_q + TAG_ONE;
          end
        end
        S_WAIT: begin
          if (word_valid_i) begin
            buf_word_q <= word_i;
            buf_tag_q  <= addr_tag_q;
            buf_vld_q  <= 1'b1;
          end
        end
        S_CROSS: begin
          if (word_valid_i) begin
            hold_q     <= {word_i[15:0], half_q};
            buf_word_q <= word_i;
            buf_tag_q  <= addr_tag_q;
            buf_vld_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_o       = INSTR_NOP;
    instr_valid_o = 1'b0;
    is_comp_o     = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_LOOKUP: begin
          if (hit && !straddle) begin
            instr_valid_o = 1'b1;
            if (h_is32) begin
              instr_o = buf_word_q;
            end else begin
              instr_o   = {16'h0000, h};
              is_comp_o = 1'b1;
            end
          end
        end
        S_HOLD: begin
          instr_o       = hold_q;
          instr_valid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fetch_req_o  = !rst && !kill && ((state_reg == S_WAIT) || (state_reg == S_CROSS));
  assign fetch_addr_o = {addr_tag_q, 2'b00};
  assign req_kill_o   = !rst && kill;
  assign stall_o      = ~instr_valid_o;

endmodule
